// File: rtl/mesh_port_arbiter.sv
// rtl/mesh_port_arbiter.sv - round-robin packet-locking arbiter for one mesh output link
module mesh_port_arbiter #(
  parameter int BUS_SIZE   = 4,
  parameter int REQ_NUM    = 5,
  parameter int PACKET_LEN = 3
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [REQ_NUM*BUS_SIZE-1:0] req_data_i,
  input  logic [REQ_NUM-1:0]          req_w_i,
  output logic [REQ_NUM-1:0]          req_r_o,
  output logic [BUS_SIZE-1:0]         data_o,
  output logic                        out_w_o,
  input  logic                        out_r_i,
  output logic [REQ_NUM-1:0]          grant_o,
  output logic                        busy_o
);

  localparam int IDX_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
  localparam int CNT_W = $clog2(PACKET_LEN + 1);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic             transfer;
  logic             last_flit;

  // Round-robin pick: first requesting source scanning ptr, ptr+1, ... with wrap.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      for (int k = 0; k < REQ_NUM; k++) begin
        if (!sel_found && req_w_i[k] && (((int'(ptr_q) + i) % REQ_NUM) == k)) begin
          sel_found = 1'b1;
          sel_idx   = IDX_W'(k);
        end
      end
    end
  end

  // Link-side outputs: everything is driven to zero unless a packet is locked.
  always_comb begin
    grant_o = '0;
    req_r_o = '0;
    data_o  = '0;
    out_w_o = 1'b0;
    busy_o  = 1'b0;
    if (state_q == LOCKED) begin
      busy_o = 1'b1;
      for (int k = 0; k < REQ_NUM; k++) begin
        if (gnt_idx_q == IDX_W'(k)) begin
          grant_o[k] = 1'b1;
          req_r_o[k] = out_r_i;
          out_w_o    = req_w_i[k];
          data_o     = req_data_i[k*BUS_SIZE +: BUS_SIZE];
        end
      end
    end
  end

  assign transfer  = out_w_o & out_r_i;
  assign last_flit = (cnt_q == CNT_W'(PACKET_LEN - 1));

  // Next-state: grant in IDLE, count flits in LOCKED, release and advance ptr on the last flit.
  always_comb begin
    state_d   = state_q;
    gnt_idx_d = gnt_idx_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (sel_found) begin
          state_d   = LOCKED;
          gnt_idx_d = sel_idx;
          cnt_d     = '0;
        end
      end
      LOCKED: begin
        if (transfer) begin
          if (last_flit) begin
            state_d = IDLE;
            cnt_d   = '0;
            ptr_d   = (gnt_idx_q == IDX_W'(REQ_NUM - 1)) ? '0 : gnt_idx_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset; reset abandons any partial packet.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      gnt_idx_q <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_idx_q <= gnt_idx_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mesh_port_arbiter.sv
// tb/tb_mesh_port_arbiter.sv - directed self-checking bench for mesh_port_arbiter
module tb_mesh_port_arbiter;

  localparam int BUS_SIZE   = 4;
  localparam int REQ_NUM    = 5;
  localparam int PACKET_LEN = 3;

  logic                        clk;
  logic                        rst;
  logic [REQ_NUM*BUS_SIZE-1:0] req_data;
  logic [REQ_NUM-1:0]          req_w;
  logic [REQ_NUM-1:0]          req_r;
  logic [BUS_SIZE-1:0]         data_out;
  logic                        out_w;
  logic                        out_r;
  logic [REQ_NUM-1:0]          grant;
  logic                        busy;

  int checks = 0;
  int errors = 0;

  mesh_port_arbiter #(
    .BUS_SIZE  (BUS_SIZE),
    .REQ_NUM   (REQ_NUM),
    .PACKET_LEN(PACKET_LEN)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .req_data_i(req_data),
    .req_w_i   (req_w),
    .req_r_o   (req_r),
    .data_o    (data_out),
    .out_w_o   (out_w),
    .out_r_i   (out_r),
    .grant_o   (grant),
    .busy_o    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then changed mid-cycle.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    logic [REQ_NUM-1:0] exp_g;

    // 1. reset with random inputs
    rst      = 1'b1;
    req_w    = REQ_NUM'($urandom);
    req_data = REQ_NUM*BUS_SIZE'($urandom);
    out_r    = 1'($urandom);
    tick();
    tick();
    settle();
    check_eq("rst_grant", 32'(grant), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_out_w", 32'(out_w), 32'h0);
    check_eq("rst_req_r", 32'(req_r), 32'h0);
    check_eq("rst_data", 32'(data_out), 32'h0);

    // 2. single source 2, flits A B C
    rst      = 1'b0;
    req_w    = 5'b00100;
    req_data = '0;
    req_data[8 +: 4] = 4'hA;
    out_r    = 1'b1;
    settle();
    check_eq("s2_idle_grant", 32'(grant), 32'h0);
    tick();
    settle();
    check_eq("s2_grant", 32'(grant), 32'b00100);
    check_eq("s2_busy", 32'(busy), 32'h1);
    check_eq("s2_out_w", 32'(out_w), 32'h1);
    check_eq("s2_req_r", 32'(req_r), 32'b00100);
    check_eq("s2_data_a", 32'(data_out), 32'hA);
    tick();
    req_data[8 +: 4] = 4'hB;
    settle();
    check_eq("s2_data_b", 32'(data_out), 32'hB);
    tick();
    req_data[8 +: 4] = 4'hC;
    settle();
    check_eq("s2_data_c", 32'(data_out), 32'hC);
    check_eq("s2_req_r_c", 32'(req_r), 32'b00100);
    tick();
    req_w = 5'b00101;
    settle();
    check_eq("s2_after_busy", 32'(busy), 32'h0);
    check_eq("s2_after_grant", 32'(grant), 32'h0);
    tick();
    settle();
    check_eq("s2_ptr3_pick0", 32'(grant), 32'b00001);
    tick();
    tick();
    tick();
    req_w = '0;
    settle();
    check_eq("s2_done_busy", 32'(busy), 32'h0);

    // 3. full contention from ptr 0
    rst = 1'b1;
    tick();
    rst   = 1'b0;
    req_w = 5'b11111;
    out_r = 1'b1;
    for (int c = 0; c < 25; c++) begin
      settle();
      exp_g = '0;
      if ((c % 4) != 0) exp_g[(c / 4) % REQ_NUM] = 1'b1;
      check_eq($sformatf("rr_c%0d", c), 32'(grant), 32'(exp_g));
      if (c == 24) req_w = '0;
      tick();
    end

    // 4. backpressure on source 1 (ptr now 1)
    req_w = 5'b00010;
    out_r = 1'b1;
    tick();
    settle();
    check_eq("bp_grant", 32'(grant), 32'b00010);
    tick();
    out_r = 1'b0;
    for (int s = 0; s < 4; s++) begin
      settle();
      check_eq($sformatf("bp_stall_out_w%0d", s), 32'(out_w), 32'h1);
      check_eq($sformatf("bp_stall_req_r%0d", s), 32'(req_r), 32'h0);
      check_eq($sformatf("bp_stall_grant%0d", s), 32'(grant), 32'b00010);
      tick();
    end
    out_r = 1'b1;
    settle();
    check_eq("bp_resume_req_r", 32'(req_r), 32'b00010);
    tick();
    settle();
    check_eq("bp_third_flit_busy", 32'(busy), 32'h1);
    tick();
    req_w = '0;
    settle();
    check_eq("bp_release_busy", 32'(busy), 32'h0);

    // 5. reset mid-packet from source 2 (ptr now 2)
    req_w = 5'b00100;
    tick();
    settle();
    check_eq("mr_grant", 32'(grant), 32'b00100);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_w = 5'b01010;
    settle();
    check_eq("mr_busy", 32'(busy), 32'h0);
    check_eq("mr_grant_idle", 32'(grant), 32'h0);
    tick();
    settle();
    check_eq("mr_ptr0_pick1", 32'(grant), 32'b00010);
    tick();
    tick();
    tick();
    req_w = '0;
    settle();
    check_eq("mr_done_busy", 32'(busy), 32'h0);

    // 6. owner gap on source 4 (ptr now 2) with source 0 waiting
    req_w = 5'b10000;
    tick();
    settle();
    check_eq("gap_grant", 32'(grant), 32'b10000);
    tick();
    req_w = 5'b00001;
    for (int g = 0; g < 2; g++) begin
      settle();
      check_eq($sformatf("gap_hold_grant%0d", g), 32'(grant), 32'b10000);
      check_eq($sformatf("gap_out_w%0d", g), 32'(out_w), 32'h0);
      tick();
    end
    req_w = 5'b10001;
    settle();
    check_eq("gap_resume_out_w", 32'(out_w), 32'h1);
    tick();
    settle();
    check_eq("gap_still_busy", 32'(busy), 32'h1);
    tick();
    req_w = 5'b00001;
    settle();
    check_eq("gap_release_busy", 32'(busy), 32'h0);
    tick();
    settle();
    check_eq("gap_next_grant0", 32'(grant), 32'b00001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
